csr_rmw_unit: RTL and testbench

// - Multi-cycle CSR read-modify-write engine in writeback; executes Zicsr ops on a parametrised local CSR file.
// - Accepts one decoded CSR op per valid/ready handshake: read old value, apply RW/RS/RC, commit, return rd data.
// - Applies read/write suppression rules and flags illegal accesses to the trap logic.

---
 rtl/csr_rmw_unit.sv | 185 ++++++++++++++++++
 tb/tb_csr_rmw_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: multi-cycle Zicsr read-modify-write engine over a small local CSR file.
// Build option CSR_COUNTERS_EN adds read-only 64-bit cycle/instret counters at 0xC00/0xC80/0xC02/0xC82.
module csr_rmw_unit #(
  parameter int          XLEN          = 32,
  parameter int          NUM_CSR       = 8,
  parameter logic [11:0] CSR_BASE_ADDR = 12'h300
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_write_func,
  input  logic            req_input_sel,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1_or_uimm,
  input  logic [XLEN-1:0] req_rs1_value,
  input  logic [11:0]     req_csr_addr,
  input  logic            retire,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd,
  output logic            resp_rd_we,
  output logic [XLEN-1:0] resp_rd_data,
  output logic            resp_illegal
);
  // state   | meaning
  // S_IDLE  | waiting for an op, req_ready high
  // S_READ  | decode address, capture old value and enables
  // S_WRITE | commit modified value to the CSR file
  // S_RESP  | hold result until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [1:0]  F_NONE    = 2'b00;
  localparam logic [1:0]  F_RW      = 2'b01;
  localparam logic [1:0]  F_RS      = 2'b10;
  localparam logic [11:0] NUM_CSR_W = 12'(NUM_CSR);

  state_t          r_state, w_next;
  logic [1:0]      r_func;
  logic            r_sel;
  logic [4:0]      r_rd, r_src_idx;
  logic [XLEN-1:0] r_rs1_value;
  logic [11:0]     r_addr;
  logic            r_read_en, r_write_en, r_illegal;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_csr [NUM_CSR];

  logic [11:0]     w_offset;
  logic            w_in_file, w_cnt_hit;
  logic [XLEN-1:0] w_file_rd, w_cnt_val, w_src, w_new;
  logic            w_read_en, w_write_en, w_illegal, w_accept, w_commit;

  assign w_accept = req_valid && req_ready;
  assign resp_rd  = r_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rd_we   = 1'b0;
    resp_rd_data = '0;
    resp_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_READ;
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = r_illegal;
        resp_rd_we   = r_read_en && !r_illegal && (r_rd != 5'd0);
        if (r_read_en && !r_illegal) resp_rd_data = r_old;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_func      <= F_NONE;
      r_sel       <= 1'b0;
      r_rd        <= 5'd0;
      r_src_idx   <= 5'd0;
      r_rs1_value <= '0;
      r_addr      <= 12'd0;
    end else if (w_accept) begin
      r_func      <= req_write_func;
      r_sel       <= req_input_sel;
      r_rd        <= req_rd;
      r_src_idx   <= req_rs1_or_uimm;
      r_rs1_value <= req_rs1_value;
      r_addr      <= req_csr_addr;
    end
  end

  assign w_offset  = r_addr - CSR_BASE_ADDR;
  assign w_in_file = (r_addr >= CSR_BASE_ADDR) && (w_offset < NUM_CSR_W);

  always_comb begin
    w_file_rd = '0;
    for (int i = 0; i < NUM_CSR; i++)
      if (w_offset == 12'(i)) w_file_rd = r_csr[i];
  end

  // Suppression follows the instruction's register indices, not operand values.
  assign w_read_en  = (r_func != F_RW) || (r_rd != 5'd0);
  assign w_write_en = (r_func == F_RW) || (r_src_idx != 5'd0);
  assign w_illegal  = (r_func == F_NONE) || !(w_in_file || w_cnt_hit) ||
                      (w_write_en && (r_addr[11:10] == 2'b11));

  assign w_src = r_sel ? {{(XLEN-5){1'b0}}, r_src_idx} : r_rs1_value;

  always_comb begin
    case (r_func)
      F_RW:    w_new = w_src;
      F_RS:    w_new = r_old | w_src;
      default: w_new = r_old & ~w_src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_illegal  <= 1'b0;
      r_old      <= '0;
    end else if (r_state == S_READ) begin
      r_read_en  <= w_read_en;
      r_write_en <= w_write_en;
      r_illegal  <= w_illegal;
      r_old      <= w_in_file ? w_file_rd : (w_cnt_hit ? w_cnt_val : '0);
    end
  end

  assign w_commit = (r_state == S_WRITE) && r_write_en && !r_illegal && w_in_file;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CSR; i++) r_csr[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_CSR; i++)
        if (w_offset == 12'(i)) r_csr[i] <= w_new;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_cycle, r_instret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle   <= 64'd0;
      r_instret <= 64'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (retire) r_instret <= r_instret + 64'd1;
    end
  end

  always_comb begin
    w_cnt_hit = 1'b1;
    w_cnt_val = '0;
    case (r_addr)
      12'hC00: w_cnt_val = XLEN'(r_cycle[31:0]);
      12'hC80: w_cnt_val = XLEN'(r_cycle[63:32]);
      12'hC02: w_cnt_val = XLEN'(r_instret[31:0]);
      12'hC82: w_cnt_val = XLEN'(r_instret[63:32]);
      default: w_cnt_hit = 1'b0;
    endcase
  end
`else
  logic w_unused_retire;
  assign w_unused_retire = retire;
  assign w_cnt_hit       = 1'b0;
  assign w_cnt_val       = '0;
`endif

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Self-checking bench for csr_rmw_unit: directed Zicsr cases plus randomized ops
// checked every cycle against a transaction-level model of the CSR file.
module tb_csr_rmw_unit;
  localparam int          XLEN    = 32;
  localparam int          NUM_CSR = 8;
  localparam logic [11:0] BASE    = 12'h300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_write_func;
  logic        req_input_sel;
  logic [4:0]  req_rd, req_rs1_or_uimm;
  logic [31:0] req_rs1_value;
  logic [11:0] req_csr_addr;
  logic        retire = 1'b0;
  logic        resp_valid, resp_ready;
  logic [4:0]  resp_rd;
  logic        resp_rd_we;
  logic [31:0] resp_rd_data;
  logic        resp_illegal;

  csr_rmw_unit #(.XLEN(XLEN), .NUM_CSR(NUM_CSR), .CSR_BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write_func(req_write_func), .req_input_sel(req_input_sel),
    .req_rd(req_rd), .req_rs1_or_uimm(req_rs1_or_uimm),
    .req_rs1_value(req_rs1_value), .req_csr_addr(req_csr_addr),
    .retire(retire),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_rd_we(resp_rd_we),
    .resp_rd_data(resp_rd_data), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        ill;
    int          cnt;
  } exp_t;

  logic [31:0] m_csr [NUM_CSR];
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  logic [63:0] m_cyc  = 64'd0;
  logic [63:0] m_ins  = 64'd0;
  exp_t        m_exp;

  bit          p_in_file, p_is_cnt, p_rd_en, p_wr_en, p_ill;
  int          p_idx;
  logic [31:0] p_src, p_old;
  logic [11:0] p_a;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_csr[i]) m_csr[i] = 32'd0;
      m_busy = 1'b0;
      m_age  = 0;
      m_cyc  = 64'd0;
      m_ins  = 64'd0;
    end else begin
      // counter reads see the value present during the cycle after acceptance
      if (m_busy && m_age == 0) begin
        case (m_exp.cnt)
          1: m_exp.data = m_cyc[31:0];
          2: m_exp.data = m_cyc[63:32];
          3: m_exp.data = m_ins[31:0];
          4: m_exp.data = m_ins[63:32];
          default: ;
        endcase
      end
      if (m_busy) begin
        if (m_age >= 2 && resp_ready) m_busy = 1'b0;
        else m_age++;
      end else if (req_valid) begin
        p_a       = req_csr_addr;
        p_in_file = (int'(p_a) >= int'(BASE)) && (int'(p_a) < int'(BASE) + NUM_CSR);
        p_idx     = p_in_file ? int'(p_a) - int'(BASE) : 0;
`ifdef CSR_COUNTERS_EN
        p_is_cnt  = (p_a == 12'hC00) || (p_a == 12'hC80) || (p_a == 12'hC02) || (p_a == 12'hC82);
`else
        p_is_cnt  = 1'b0;
`endif
        p_old   = p_in_file ? m_csr[p_idx] : 32'd0;
        p_rd_en = (req_write_func != 2'b01) || (req_rd != 5'd0);
        p_wr_en = (req_write_func == 2'b01) || (req_rs1_or_uimm != 5'd0);
        p_ill   = (req_write_func == 2'b00) || !(p_in_file || p_is_cnt) ||
                  (p_wr_en && p_a[11:10] == 2'b11);
        p_src   = req_input_sel ? {27'd0, req_rs1_or_uimm} : req_rs1_value;
        if (!p_ill && p_wr_en && p_in_file)
          m_csr[p_idx] = (req_write_func == 2'b01) ? p_src :
                         (req_write_func == 2'b10) ? (p_old | p_src) : (p_old & ~p_src);
        m_exp.rd   = req_rd;
        m_exp.ill  = p_ill;
        m_exp.we   = !p_ill && p_rd_en && (req_rd != 5'd0);
        m_exp.data = (!p_ill && p_rd_en) ? p_old : 32'd0;
        m_exp.cnt  = (!p_ill && p_is_cnt) ?
                     ((p_a == 12'hC00) ? 1 : (p_a == 12'hC80) ? 2 : (p_a == 12'hC02) ? 3 : 4) : 0;
        m_busy = 1'b1;
        m_age  = 0;
      end
      m_cyc = m_cyc + 64'd1;
      if (retire) m_ins = m_ins + 64'd1;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(!m_busy));
    check("resp_valid", 32'(resp_valid), 32'(m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      check("resp_rd", 32'(resp_rd), 32'(m_exp.rd));
      check("resp_rd_we", 32'(resp_rd_we), 32'(m_exp.we));
      check("resp_rd_data", resp_rd_data, m_exp.data);
      check("resp_illegal", 32'(resp_illegal), 32'(m_exp.ill));
    end
  end

  always @(negedge clk) retire = 1'($urandom_range(0, 1));

  // ---------------- driver ----------------
  logic [31:0] o_data;
  logic        o_we, o_ill;
  int          o_lat;

  task automatic do_op(input logic [1:0] f, input logic s, input logic [4:0] rd,
                       input logic [4:0] u, input logic [31:0] v, input logic [11:0] a,
                       input int hold);
    @(negedge clk);
    req_write_func = f; req_input_sel = s; req_rd = rd;
    req_rs1_or_uimm = u; req_rs1_value = v; req_csr_addr = a;
    req_valid = 1'b1;
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    o_lat = 1;
    while (!resp_valid && o_lat < 12) begin
      @(negedge clk);
      o_lat++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    o_data = resp_rd_data; o_we = resp_rd_we; o_ill = resp_illegal;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_data", resp_rd_data, o_data);
      check("hold_we", 32'(resp_rd_we), 32'(o_we));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  f;
    logic [4:0]  rd, u;
    logic [11:0] a;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_write_func = 2'b00; req_input_sel = 1'b0; req_rd = 5'd0;
    req_rs1_or_uimm = 5'd0; req_rs1_value = 32'd0; req_csr_addr = 12'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rd_we", 32'(resp_rd_we), 32'd0);
    check("rst_illegal", 32'(resp_illegal), 32'd0);
    check("rst_rd", 32'(resp_rd), 32'd0);
    check("rst_data", resp_rd_data, 32'd0);
    rst_n = 1'b1;

    do_op(2'b01, 1'b0, 5'd5, 5'd3, 32'hDEADBEEF, 12'h300, 0);
    check("rw_latency", o_lat, 32'd3);
    check("rw_we", 32'(o_we), 32'd1);
    check("rw_old", o_data, 32'd0);
    do_op(2'b10, 1'b0, 5'd7, 5'd0, 32'd0, 12'h300, 0);
    check("rw_commit", o_data, 32'hDEADBEEF);
    do_op(2'b10, 1'b0, 5'd0, 5'd0, 32'h0000FFFF, 12'h300, 0);
    check("rs_x0_we", 32'(o_we), 32'd0);
    check("rs_x0_legal", 32'(o_ill), 32'd0);
    do_op(2'b10, 1'b0, 5'd7, 5'd0, 32'd0, 12'h300, 0);
    check("rs_x0_nowrite", o_data, 32'hDEADBEEF);

    do_op(2'b01, 1'b0, 5'd2, 5'd4, 32'h000000FF, 12'h300, 0);
    do_op(2'b11, 1'b1, 5'd6, 5'h0F, 32'hFFFFFFFF, 12'h300, 4);
    check("rci_old", o_data, 32'h000000FF);
    check("rci_we", 32'(o_we), 32'd1);
    do_op(2'b10, 1'b0, 5'd7, 5'd0, 32'd0, 12'h300, 0);
    check("rci_commit", o_data, 32'h000000F0);

    do_op(2'b01, 1'b0, 5'd1, 5'd3, 32'h1234, 12'h3FF, 0);
    check("unmapped_ill", 32'(o_ill), 32'd1);
    check("unmapped_we", 32'(o_we), 32'd0);
    check("unmapped_data", o_data, 32'd0);
    do_op(2'b00, 1'b0, 5'd1, 5'd3, 32'h1234, 12'h300, 0);
    check("none_ill", 32'(o_ill), 32'd1);
    do_op(2'b10, 1'b0, 5'd7, 5'd0, 32'd0, 12'h300, 0);
    check("illegal_nowrite", o_data, 32'h000000F0);

`ifdef CSR_COUNTERS_EN
    repeat (100) @(negedge clk);
    do_op(2'b10, 1'b0, 5'd3, 5'd0, 32'd0, 12'hC00, 0);
    check("cycle_lo_range", 32'(o_data >= 32'd100 && o_data < 32'd200), 32'd1);
    check("cycle_legal", 32'(o_ill), 32'd0);
    do_op(2'b01, 1'b0, 5'd3, 5'd1, 32'd5, 12'hC00, 0);
    check("cycle_write_ill", 32'(o_ill), 32'd1);
`else
    do_op(2'b10, 1'b0, 5'd3, 5'd0, 32'd0, 12'hC00, 0);
    check("cycle_unmapped_ill", 32'(o_ill), 32'd1);
`endif

    // reset asserted during the WRITE cycle aborts the op
    do_op(2'b01, 1'b0, 5'd1, 5'd2, 32'h1234, 12'h301, 0);
    @(negedge clk);
    req_write_func = 2'b01; req_input_sel = 1'b0; req_rd = 5'd1;
    req_rs1_or_uimm = 5'd2; req_rs1_value = 32'h5555; req_csr_addr = 12'h301;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    do_op(2'b10, 1'b0, 5'd7, 5'd0, 32'd0, 12'h301, 0);
    check("abort_csr1", o_data, 32'd0);

    for (int n = 0; n < 300; n++) begin
      f  = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      u  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 12'($urandom_range(0, 9));
        3: begin
          case ($urandom_range(0, 3))
            0: a = 12'hC00;
            1: a = 12'hC80;
            2: a = 12'hC02;
            default: a = 12'hC82;
          endcase
        end
        4: a = 12'h3FF;
        default: a = 12'($urandom);
      endcase
      do_op(f, 1'($urandom_range(0, 1)), rd, u, $urandom, a, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
